par2ser_tx: RTL
===============

Name: par2ser_tx

Overview:
- Transmit-side counterpart to the width-parameterised 1-bit-to-wide receive path.
- Accepts a SIZE-bit parallel word on a valid/ready handshake and emits it one bit per beat on a serial valid/ready channel.
- Marks the first and last beats of each word.
- Exercises width-parameter elaboration rules: the derived top index SIZE-1 must never go negative.

Parameters:
- SIZE, 4, word width in bits; legal range 1..1024; anything else is an elaboration error via a generate-time $error.
- MSB_FIRST, 1, 1 = bit SIZE-1 sent first; 0 = bit 0 sent first.
- localparam CNT_W, $clog2(SIZE+1), width of the beat counter; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  parallel word offered.
- in_ready  output  1  block will take the word this cycle.
- in_data  input  SIZE  parallel word.
- out_valid  output  1  serial bit valid.
- out_ready  input  1  consumer takes the bit this cycle.
- out_bit  output  1  serial data.
- out_first  output  1  current beat is beat 0 of a word.
- out_last  output  1  current beat is the final beat of a word.
- busy  output  1  word in flight (state != IDLE).

Behaviour:
- Reset, asynchronous assertion: state=IDLE, shift register=0, counter=0. Outputs: out_valid=0, out_bit=0, out_first=0, out_last=0, busy=0. in_ready=1 once reset_n is high.
- States: IDLE, SHIFT, plus PARITY when the optional feature is enabled.
- IDLE:
  - in_ready=1.
  - When in_valid is high, latch in_data, set counter=0 and go to SHIFT.
  - First bit appears on out_valid on the next cycle; latency is 1 cycle.
- SHIFT:
  - out_valid=1; out_bit is the current head bit (MSB or LSB per MSB_FIRST).
  - out_first=(counter==0); out_last=(counter==SIZE-1) and parity disabled.
  - A beat transfers when out_valid&&out_ready: shift the register and increment the counter.
  - If out_ready=0, out_bit, out_first, out_last and the counter all hold. Every output is stable under stall.
- End of word:
  - A transfer with counter==SIZE-1 ends the word; go to IDLE, or to PARITY if the feature is enabled.
  - Back-to-back: in_ready is also 1 during SHIFT when the last beat transfers this cycle (in_ready = idle | (shift & last & out_ready)). in_ready therefore depends combinationally on out_ready.
  - If in_valid is high on that cycle, the new word loads directly, state stays SHIFT, and there is no bubble.
- SIZE=1: out_first and out_last are both high on the single beat.
- Counter compares are done at CNT_W bits, with SIZE-1 cast to CNT_W. There is no signed arithmetic anywhere.
- in_data is ignored whenever in_ready=0.
- Reset mid-word: the word is discarded; no partial beats resume.

Optional Feature:
- Macro PAR2SER_TX_PARITY_EN.
- Defined:
  - After the last data beat, go to PARITY and emit one extra beat: out_bit = even parity (XOR) of the latched word.
  - In that beat out_first=0 and out_last=1; on data beats out_last=0.
  - The back-to-back load happens on the parity beat transfer instead of the last data beat.
  - Each word takes SIZE+1 beats.
- Undefined: no PARITY state and no parity logic; SIZE beats per word.

Decomposition:
- Package par2ser_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - the SIZE legality bounds, MIN_SIZE=1 and MAX_SIZE=1024.
- One sub-module, par2ser_beat_cnt: a CNT_W-bit counter with clear, enable and an is_last compare against a SIZE-1 parameter. It is shared with the receive side.

Test Plan:
- Single word: SIZE=4, MSB_FIRST=1, in_data=4'b1011, out_ready=1 -> out_bit 1,0,1,1 on cycles N+1..N+4; out_first only on N+1; out_last only on N+4; busy high N+1..N+4.
- Streaming: SIZE=4, words 4'hA then 4'h5 with in_valid held high -> in_ready pulses on the last beat of the first word; 8 consecutive beats 1,0,1,0,0,1,0,1 with no gap.
- Stall and LSB-first: out_ready=0 for 3 cycles after beat 1 of 4'b1100 with MSB_FIRST=0 -> out_bit holds 0 and counter holds; sequence still 0,0,1,1 after release.
- Reset mid-word: reset_n low during beat 2 -> out_valid drops immediately, busy=0; the next word starts with out_first=1.
- Degenerate width: SIZE=1, in_data=1 -> one beat with out_bit=1, out_first=1, out_last=1. SIZE=0 -> elaboration fails.
- Parity (PAR2SER_TX_PARITY_EN): SIZE=4, 4'b0111 -> beats 0,1,1,1 then parity beat 1 with out_last=1 only on that beat.

Source files
------------

// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared state encoding and width bounds for the parallel/serial converters.
package par2ser_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    localparam int MIN_SIZE = 1;
    localparam int MAX_SIZE = 1024;
endpackage

// File: rtl/par2ser_beat_cnt.sv
// par2ser_beat_cnt: beat counter with clear/enable and a compare against the final beat index.
module par2ser_beat_cnt #(
    parameter int W    = 1,
    parameter int LAST = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);
    localparam logic [W-1:0] LAST_C = W'(LAST);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d  = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
    assign cnt_o  = cnt_q;
    assign last_o = cnt_q == LAST_C;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/par2ser_tx.sv
// par2ser_tx: serialises a SIZE-bit word onto a 1-bit valid/ready channel with first/last marks.
// Optional trailing even-parity beat when PAR2SER_TX_PARITY_EN is defined.
module par2ser_tx
    import par2ser_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_first,
    output logic            out_last,
    output logic            busy
);
    localparam int CNT_W = $clog2(SIZE + 1);

    generate
        if (SIZE < MIN_SIZE || SIZE > MAX_SIZE) begin : g_bad_size
            $error("par2ser_tx: SIZE out of range");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [SIZE-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt;
    logic            cnt_last, idle, shift, beat, load, word_end, head;

    assign idle      = state_q == IDLE;
    assign shift     = state_q == SHIFT;
    assign head      = MSB_FIRST ? sr_q[SIZE-1] : sr_q[0];
    assign out_valid = !idle;
    assign busy      = !idle;
    assign beat      = out_valid & out_ready;
    // Ready also opens on the closing beat so a queued word follows with no bubble.
    assign in_ready  = idle | (word_end & out_ready);
    assign load      = in_valid & in_ready;
    assign out_first = shift & (cnt == '0);
    assign out_last  = word_end;

`ifdef PAR2SER_TX_PARITY_EN
    logic par_q;
    assign word_end = state_q == PARITY;
    assign out_bit  = shift ? head : word_end & par_q;
`else
    assign word_end = shift & cnt_last;
    assign out_bit  = shift & head;
`endif

    par2ser_beat_cnt #(.W(CNT_W), .LAST(SIZE - 1)) u_cnt (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr_i  (load | (beat & shift & cnt_last)),
        .en_i   (beat & shift),
        .cnt_o  (cnt),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        if (load) begin
            state_d = SHIFT;
            sr_d    = in_data;
        end else if (beat) begin
            sr_d = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
            if (word_end) state_d = IDLE;
`ifdef PAR2SER_TX_PARITY_EN
            else if (cnt_last) state_d = PARITY;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
`ifdef PAR2SER_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
`ifdef PAR2SER_TX_PARITY_EN
            if (load) par_q <= ^in_data;
`endif
        end
endmodule
